// File: rtl/aes_shiftrows_mixcol_collect.sv
// aes_shiftrows_mixcol_collect
// Collects the S-box/key-add stage output one byte per cycle, scattering each
// byte straight to its ShiftRows position. It then runs MixColumns in place,
// COLS_PER_CYCLE columns per cycle, or skips it for the last round. Finally it
// offers the 128-bit state downstream with a valid/ready handshake.
// Byte k of the state (k = 4*col + row) sits at bits [127-8k -: 8].

module aes_shiftrows_mixcol_collect #(
  parameter int COLS_PER_CYCLE = 1  // 1, 2 or 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         io_in_valid,
  output logic         io_in_ready,
  input  logic [7:0]   io_in_byte,
  output logic [3:0]   io_byteIdx,
  input  logic         io_lastRound,
  output logic         io_out_valid,
  input  logic         io_out_ready,
  output logic [127:0] io_out_data,
  output logic         io_busy
);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_MIX  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // The column counter advances by COL_STEP. It wraps to 0 for 4 columns per
  // cycle. Column c is in the current group when its index masked by COL_MASK
  // equals the counter. COL_LAST is the counter value of the final group.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] COL_MASK = 2'(~(COLS_PER_CYCLE - 1));
  localparam logic [1:0] COL_LAST = 2'(4 - COLS_PER_CYCLE);

  state_t         state_reg, state_next;
  logic [127:0]   buf_reg, buf_next;
  logic [3:0]     byte_idx_reg, byte_idx_next;
  logic           last_rnd_reg, last_rnd_next;
  logic [1:0]     col_cnt_reg, col_cnt_next;

  logic           accept;
  logic [3:0]     fill_pos;
  logic [127:0]   mix_data;
  logic [3:0]     col_active;

  // GF(2^8) multiply by 2, reducing by the AES polynomial when the MSB falls out.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // The ShiftRows destination of input byte k is column (c - r) mod 4, row r.
  // The 2-bit subtraction gives the mod 4 wrap.
  assign fill_pos = {byte_idx_reg[3:2] - byte_idx_reg[1:0], byte_idx_reg[1:0]};

  // MixColumns result for every column. The buffer only takes the columns
  // of the current group.
  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = buf_reg[127 - 32*gi      -: 8];
    assign a1 = buf_reg[127 - 32*gi - 8  -: 8];
    assign a2 = buf_reg[127 - 32*gi - 16 -: 8];
    assign a3 = buf_reg[127 - 32*gi - 24 -: 8];

    assign mix_data[127 - 32*gi      -: 8] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    assign mix_data[127 - 32*gi - 8  -: 8] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    assign mix_data[127 - 32*gi - 16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    assign mix_data[127 - 32*gi - 24 -: 8] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);

    assign col_active[gi] = (state_reg == ST_MIX) && ((2'(gi) & COL_MASK) == col_cnt_reg);
  end

  // Control: state sequencing, byte index, last-round latch and column counter.
  always_comb begin
    state_next    = state_reg;
    byte_idx_next = byte_idx_reg;
    last_rnd_next = last_rnd_reg;
    col_cnt_next  = col_cnt_reg;
    io_in_ready   = 1'b0;
    io_out_valid  = 1'b0;
    accept        = 1'b0;
    case (state_reg)
      ST_FILL: begin
        io_in_ready = 1'b1;
        if (io_in_valid) begin
          accept        = 1'b1;
          byte_idx_next = byte_idx_reg + 4'd1;  // wraps to 0 after byte 15
          if (byte_idx_reg == 4'd15) begin
            last_rnd_next = io_lastRound;
            state_next    = io_lastRound ? ST_OUT : ST_MIX;
          end
        end
      end
      ST_MIX: begin
        col_cnt_next = col_cnt_reg + COL_STEP;
        if (col_cnt_reg == COL_LAST) begin
          col_cnt_next = 2'd0;
          state_next   = ST_OUT;
        end
      end
      ST_OUT: begin
        io_out_valid = 1'b1;
        if (io_out_ready) begin
          state_next = ST_FILL;
        end
      end
      default: begin
        state_next = ST_FILL;
      end
    endcase
  end

  // Buffer update: an incoming byte goes to its ShiftRows slot, or the active
  // columns are replaced by their MixColumns result.
  always_comb begin
    buf_next = buf_reg;
    for (int i = 0; i < 16; i++) begin
      if (accept && (fill_pos == 4'(i))) begin
        buf_next[127 - 8*i -: 8] = io_in_byte;
      end else if (col_active[i / 4]) begin
        buf_next[127 - 8*i -: 8] = mix_data[127 - 8*i -: 8];
      end
    end
  end

  // State registers. Reset discards any partial state and clears the buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_FILL;
      buf_reg      <= '0;
      byte_idx_reg <= 4'd0;
      last_rnd_reg <= 1'b0;
      col_cnt_reg  <= 2'd0;
    end else begin
      state_reg    <= state_next;
      buf_reg      <= buf_next;
      byte_idx_reg <= byte_idx_next;
      last_rnd_reg <= last_rnd_next;
      col_cnt_reg  <= col_cnt_next;
    end
  end

  assign io_byteIdx  = byte_idx_reg;
  assign io_out_data = buf_reg;
  assign io_busy     = (state_reg == ST_MIX) || (state_reg == ST_OUT);

endmodule

// File: doc/aes_shiftrows_mixcol_collect.md
Name: aes_shiftrows_mixcol_collect

Overview:
- Downstream neighbour of the byte-level S-box/key-add stage in the DFA case-study datapath.
- Accepts that stage's output one byte per cycle and places each byte at its ShiftRows destination in a 16-byte buffer.
- Then applies MixColumns one or more columns per cycle, or bypasses it for the last round.
- Presents the finished 128-bit state to the next consumer with a valid/ready handshake.

Parameters:
- COLS_PER_CYCLE, 1, MixColumns columns processed per cycle. Legal values are 1, 2, 4. MIX phase length is 4/COLS_PER_CYCLE cycles.

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- io_in_valid  input  1  upstream byte valid
- io_in_ready  output  1  block accepts a byte this cycle
- io_in_byte  input  8  byte from the S-box/key-add stage
- io_byteIdx  output  4  index k (0..15) of the next expected input byte; drives upstream state/key byte selection
- io_lastRound  input  1  sampled with byte 15; 1 = skip MixColumns
- io_out_valid  output  1  io_out_data holds a completed state
- io_out_ready  input  1  downstream accepts the state
- io_out_data  output  128  completed state; byte k at bits [127-8k:120-8k]
- io_busy  output  1  high in MIX and OUT

Behaviour:
- Byte numbering is column-major: k = 4c + r (row r, column c), per FIPS-197.
- Input byte k is written to buffer position 4*((c - r) mod 4) + r. This is ShiftRows.
- FSM states: FILL, MIX, OUT.
- FILL:
  - io_in_ready = 1.
  - A byte is accepted when io_in_valid & io_in_ready. On accept, the byte is written and io_byteIdx increments.
  - No accept means no change; gaps of any length are legal.
  - On accepting k = 15: latch io_lastRound into lastRnd and reset io_byteIdx to 0.
  - Next state is OUT if lastRnd = 1, else MIX.
- MIX:
  - io_in_ready = 0. io_in_valid is ignored and no byte is lost or consumed.
  - Each cycle, replace COLS_PER_CYCLE columns in place with the MixColumns result. Column counter starts at 0.
  - MixColumns per column: s'0 = 2a0^3a1^a2^a3; s'1 = a0^2a1^3a2^a3; s'2 = a0^a1^2a2^3a3; s'3 = 3a0^a1^a2^2a3.
  - GF(2^8) xtime: reduce by 0x1B when the MSB is set.
  - After the final column, go to OUT.
- OUT:
  - io_out_valid = 1. io_out_data is the buffer, held stable until handshake.
  - On io_out_ready = 1, the next cycle is FILL with io_out_valid = 0.
  - io_out_ready is ignored outside OUT.
- io_out_data is driven directly from the buffer in all states. It is defined only when io_out_valid = 1.
- Latency, with byte 15 accepted at edge T:
  - io_out_valid rises after T + 4/COLS_PER_CYCLE + 1 edges in mix mode.
  - io_out_valid rises after T + 1 edges in last-round mode.
- Back-to-back: the first byte of the next state can be accepted in the first FILL cycle after the OUT handshake. No overlap of FILL with OUT.
- Reset, synchronous and taking effect at any point including mid-FILL or mid-MIX:
  - state = FILL, io_byteIdx = 0, lastRnd = 0, column counter = 0, buffer = 0.
  - Outputs after the reset edge: io_in_ready = 1, io_out_valid = 0, io_busy = 0, io_out_data = 0.
  - A partially collected state is discarded.
  - A byte presented in the same cycle reset is high is not accepted.
- io_lastRound is sampled only on the byte-15 accept; its value at any other time has no effect.

Test Plan:
1. MixColumns vector: feed 16 bytes such that the post-ShiftRows state is the FIPS-197 Round-1 after-ShiftRows state (column 0 = d4 bf 5d 30), io_lastRound = 0 -> out column 0 = 04 66 81 e5; all four columns match FIPS-197 after-MixColumns.
2. Identity columns: post-ShiftRows columns {01 01 01 01}, {c6 c6 c6 c6}, {db 13 53 45}, {f2 0a 22 5c} -> {01 01 01 01}, {c6 c6 c6 c6}, {8e 4d a1 bc}, {9f dc 58 9d}.
3. ShiftRows only: io_lastRound = 1, input bytes k = 0x00..0x0F -> io_out_data = 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b; io_out_valid one cycle after byte 15.
4. Handshake stress: random io_in_valid gaps and io_out_ready held low 10 cycles -> io_out_data stable while waiting, io_in_ready = 0 throughout MIX/OUT, io_byteIdx counts only accepted bytes; run for each COLS_PER_CYCLE value (1, 2, 4) with latency matching 5, 3, 2 cycles.
5. Reset mid-operation: assert reset after byte 7 and again during MIX -> next cycle io_byteIdx = 0, io_out_valid = 0; a fresh 16-byte state then yields the correct result.
6. Back-to-back: two states streamed with io_out_ready = 1 -> second output correct; its first byte is accepted in the cycle after the first handshake.
